vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 87 ++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Free-running horizontal/vertical counters with sync, blank and start strobes.
// Every output is a flop. The strobes are decoded from the next-state counts, so
// each one describes the DrawX/DrawY pair that is registered on the same edge.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] XMax    = 10'(H_TOTAL - 1);
  localparam logic [9:0] YMax    = 10'(V_TOTAL - 1);
  localparam logic [9:0] XActive = 10'(H_ACTIVE);
  localparam logic [9:0] YActive = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_d;
  logic [9:0] y_d;
  logic       x_wrap;
  logic       hs_d;
  logic       vs_d;
  logic       blank_d;
  logic       line_start_d;
  logic       frame_start_d;

  // Next counter values and the decode of the position they will present.
  always_comb begin
    x_wrap = (DrawX == XMax);
    x_d    = x_wrap ? 10'd0 : DrawX + 10'd1;
    y_d    = DrawY;
    if (x_wrap) begin
      y_d = (DrawY == YMax) ? 10'd0 : DrawY + 10'd1;
    end
    hs_d          = !((x_d >= HsStart) && (x_d < HsEnd));
    vs_d          = !((y_d >= VsStart) && (y_d < VsEnd));
    blank_d       = (x_d < XActive) && (y_d < YActive);
    line_start_d  = (x_d == 10'd0);
    frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
  end

  // Register counters and decoded outputs; reset parks at the last pixel of a
  // frame so the first counting edge lands on (0,0).
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= XMax;
      DrawY       <= YMax;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      DrawX       <= x_d;
      DrawY       <= y_d;
      hs          <= hs_d;
      vs          <= vs_d;
      blank       <= blank_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
      frame_count <= frame_count + {15'd0, frame_start_d};
    end
  end

endmodule
